// File: rtl/xge_mac_pkg.sv
// Shared 10GE MAC definitions: link fault codes, XGMII control characters,
// fault ordered-set words and the TX fault sequencer state type.
package xge_mac_pkg;

  localparam logic [1:0] LINK_FAULT_OK     = 2'd0;
  localparam logic [1:0] LINK_FAULT_LOCAL  = 2'd1;
  localparam logic [1:0] LINK_FAULT_REMOTE = 2'd2;

  localparam logic [7:0] XGMII_IDLE      = 8'h07;
  localparam logic [7:0] XGMII_START     = 8'hFB;
  localparam logic [7:0] XGMII_TERMINATE = 8'hFD;
  localparam logic [7:0] XGMII_SEQUENCE  = 8'h9C;

  // Remote Fault ordered set, one 32-bit column, byte0 in the low bits
  localparam logic [31:0] RF_COLUMN_D = {8'h02, 8'h00, 8'h00, XGMII_SEQUENCE};
  localparam logic [3:0]  RF_COLUMN_C = 4'b0001;

  localparam logic [63:0] RF_WORD_D   = {2{RF_COLUMN_D}};
  localparam logic [7:0]  RF_WORD_C   = {2{RF_COLUMN_C}};
  localparam logic [63:0] IDLE_WORD_D = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_WORD_C = '1;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    DRAIN     = 2'd1,
    SEND_RF   = 2'd2,
    SEND_IDLE = 2'd3
  } tx_fault_state_t;

  // True when a byte lane carries the given control character
  function automatic logic is_ctrl_char(input logic [7:0] data, input logic ctrl,
                                        input logic [7:0] ch);
    return ctrl && (data == ch);
  endfunction

endpackage

// File: rtl/xgmii_frame_tracker.sv
// Tracks frame occupancy of a 64-bit XGMII TX word stream: Start in lane 0 or
// lane 4, Terminate in any byte. boundary is high when the stream is outside a
// frame after the current word.
import xge_mac_pkg::*;

module xgmii_frame_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output logic        start_seen,
  output logic        boundary
);

  logic in_frame;
  logic in_frame_next;
  logic start_lo;
  logic start_hi;
  logic term_lo;
  logic term_hi;

  assign start_lo   = is_ctrl_char(txd[7:0],   txc[0], XGMII_START);
  assign start_hi   = is_ctrl_char(txd[39:32], txc[4], XGMII_START);
  assign start_seen = start_lo | start_hi;

  // Terminate detection split by column so byte order against a lane-4 Start is known
  always_comb begin
    term_lo = 1'b0;
    term_hi = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (is_ctrl_char(txd[8*i +: 8], txc[i], XGMII_TERMINATE))
        term_lo = 1'b1;
      if (is_ctrl_char(txd[32+8*i +: 8], txc[4+i], XGMII_TERMINATE))
        term_hi = 1'b1;
    end
  end

  // Later bytes win: an upper Terminate ends any frame, a lane-4 Start reopens
  // after a lower Terminate, a lane-0 Start is overridden by a later Terminate.
  always_comb begin
    if (term_hi)       in_frame_next = 1'b0;
    else if (start_hi) in_frame_next = 1'b1;
    else if (term_lo)  in_frame_next = 1'b0;
    else if (start_lo) in_frame_next = 1'b1;
    else               in_frame_next = in_frame;
  end

  assign boundary = ~in_frame_next;

  // Frame occupancy register
  always_ff @(posedge clk) begin
    if (reset) in_frame <= 1'b0;
    else       in_frame <= in_frame_next;
  end

endmodule

// File: rtl/tx_fault_seq.sv
// XGMII TX link fault responder: passes MAC words, or replaces them with
// Remote Fault (local fault seen) or Idle (remote fault seen), switching only
// at frame boundaries and holding the override HOLD_CYCLES clocks after the
// fault clears. Optional statistics ports enabled by TX_FAULT_STATS_EN.
import xge_mac_pkg::*;

module tx_fault_seq #(
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx,
  input  logic [1:0]  link_fault,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        mac_tx_hold,
  output logic        status_fault_tx
`ifdef TX_FAULT_STATS_EN
  ,
  output logic [15:0] stat_fault_entries,
  output logic [15:0] stat_frames_dropped
`endif
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  tx_fault_state_t state;
  tx_fault_state_t state_next;
  tx_fault_state_t fault_target;
  logic [HW-1:0]   hold_cnt;
  logic            fault;
  logic            in_override;
  logic            next_override;
  logic            boundary;
  logic            start_seen;

  xgmii_frame_tracker u_tracker (
    .clk        (clk_xgmii_tx),
    .reset      (reset_xgmii_tx),
    .txd        (mac_txd),
    .txc        (mac_txc),
    .start_seen (start_seen),
    .boundary   (boundary)
  );

  assign fault         = (link_fault != LINK_FAULT_OK);
  // 2'b11 is not a legal code and is handled as a local fault
  assign fault_target  = (link_fault == LINK_FAULT_REMOTE) ? SEND_IDLE : SEND_RF;
  assign in_override   = (state == SEND_RF) || (state == SEND_IDLE);
  assign next_override = (state_next == SEND_RF) || (state_next == SEND_IDLE);

  assign mac_tx_hold     = (state != PASS);
  assign status_fault_tx = in_override;

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      PASS: begin
        if (fault) state_next = boundary ? fault_target : DRAIN;
      end
      DRAIN: begin
        if (boundary) state_next = fault ? fault_target : PASS;
      end
      default: begin
        if (fault)                                   state_next = fault_target;
        else if (hold_cnt == HOLD_MAX && boundary)   state_next = PASS;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) state <= PASS;
    else                state <= state_next;
  end

  // Hold timer: counts fault-free clocks in an override state, saturating
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx)              hold_cnt <= '0;
    else if (fault || !in_override)  hold_cnt <= '0;
    else if (hold_cnt != HOLD_MAX)   hold_cnt <= hold_cnt + 1'b1;
  end

  // Output word register: one clock latency in every state
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      xgmii_txd <= IDLE_WORD_D;
      xgmii_txc <= IDLE_WORD_C;
    end else begin
      case (state)
        SEND_RF: begin
          xgmii_txd <= RF_WORD_D;
          xgmii_txc <= RF_WORD_C;
        end
        SEND_IDLE: begin
          xgmii_txd <= IDLE_WORD_D;
          xgmii_txc <= IDLE_WORD_C;
        end
        default: begin
          xgmii_txd <= mac_txd;
          xgmii_txc <= mac_txc;
        end
      endcase
    end
  end

`ifdef TX_FAULT_STATS_EN
  // Saturating counts of override entries and of frames started during override
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      stat_fault_entries  <= '0;
      stat_frames_dropped <= '0;
    end else begin
      if (!in_override && next_override && stat_fault_entries != '1)
        stat_fault_entries <= stat_fault_entries + 1'b1;
      if (in_override && start_seen && stat_frames_dropped != '1)
        stat_frames_dropped <= stat_frames_dropped + 1'b1;
    end
  end
`else
  logic unused_start_seen;
  assign unused_start_seen = start_seen;
`endif

endmodule

// File: tb/tb_tx_fault_seq.sv
// Scoreboard bench for tx_fault_seq: stimulus process drives one word per
// clock and pushes the reference model's expectation; a monitor pops and
// compares after every clock edge. Stats ports checked when TX_FAULT_STATS_EN.
`timescale 1ns/1ps

module tb_tx_fault_seq;

  localparam int unsigned HOLD = 64;
  localparam logic [63:0] W_IDLE = 64'h0707070707070707;
  localparam logic [63:0] W_RF   = 64'h0200009C0200009C;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  lf;
  logic [63:0] mtxd;
  logic [7:0]  mtxc;
  logic [63:0] xtxd;
  logic [7:0]  xtxc;
  logic        hold;
  logic        sft;
`ifdef TX_FAULT_STATS_EN
  logic [15:0] s_ent;
  logic [15:0] s_drop;
`endif

  always #5 clk = ~clk;

  tx_fault_seq #(.HOLD_CYCLES(HOLD)) dut (
    .clk_xgmii_tx    (clk),
    .reset_xgmii_tx  (rst),
    .link_fault      (lf),
    .mac_txd         (mtxd),
    .mac_txc         (mtxc),
    .xgmii_txd       (xtxd),
    .xgmii_txc       (xtxc),
    .mac_tx_hold     (hold),
    .status_fault_tx (sft)
`ifdef TX_FAULT_STATS_EN
    ,
    .stat_fault_entries  (s_ent),
    .stat_frames_dropped (s_drop)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        hold;
    logic        stat;
    int          ent;
    int          drop;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: what the link is doing, in plain terms
  bit m_draining;   // finishing the MAC's frame before overriding
  int m_override;   // 0 = MAC data on the wire, 1 = sending RF, 2 = sending Idle
  int m_ok_clocks;  // fault-free clocks seen while overriding (saturates at HOLD)
  bit m_in_frame;
  int m_ent;
  int m_drop;

  task automatic model_step(input logic [63:0] d, input logic [7:0] c,
                            input logic [1:0] f, input bit r);
    exp_t e;
    bit   nf;
    int   starts;
    bit   fault;
    int   want;
    if (r) begin
      m_draining = 0; m_override = 0; m_ok_clocks = 0; m_in_frame = 0;
      m_ent = 0; m_drop = 0;
      e.d = W_IDLE; e.c = 8'hFF;
    end else begin
      // walk bytes in wire order; the last Start/Terminate wins
      nf = m_in_frame; starts = 0;
      for (int b = 0; b < 8; b++) begin
        logic [7:0] by;
        by = d[8*b +: 8];
        if (c[b] && by == 8'hFD) nf = 0;
        else if (c[b] && by == 8'hFB && (b == 0 || b == 4)) begin
          nf = 1; starts++;
        end
      end
      if (m_override == 1)      begin e.d = W_RF;   e.c = 8'h11; end
      else if (m_override == 2) begin e.d = W_IDLE; e.c = 8'hFF; end
      else                      begin e.d = d;      e.c = c;     end
      fault = (f != 2'd0);
      want  = (f == 2'd2) ? 2 : 1;
      if (m_override != 0 && starts > 0 && m_drop < 65535) m_drop++;
      if (m_override == 0) begin
        if (!m_draining) begin
          if (fault) begin
            if (!nf) m_override = want;
            else     m_draining = 1;
          end
        end else if (!nf) begin
          m_draining = 0;
          if (fault) m_override = want;
        end
        if (m_override != 0 && m_ent < 65535) m_ent++;
      end else if (fault) begin
        m_override = want; m_ok_clocks = 0;
      end else if (m_ok_clocks == HOLD && !nf) begin
        m_override = 0; m_ok_clocks = 0;
      end else if (m_ok_clocks < HOLD) begin
        m_ok_clocks++;
      end
      m_in_frame = nf;
    end
    e.hold = (m_override != 0) || m_draining;
    e.stat = (m_override != 0);
    e.ent  = m_ent;
    e.drop = m_drop;
    q.push_back(e);
  endtask

  // Word builder: 0 idle, 1 Start lane0, 2 Start lane4, 3 data,
  // 4 Terminate at byte p, 5 Terminate at byte p (<4) then Start lane4
  function automatic void mk(input int kind, input int p,
                             output logic [63:0] d, output logic [7:0] c);
    for (int b = 0; b < 8; b++) begin
      d[8*b +: 8] = 8'($urandom);
      c[b] = 1'b0;
    end
    case (kind)
      0: begin d = W_IDLE; c = 8'hFF; end
      1: begin d[7:0] = 8'hFB; c[0] = 1'b1; end
      2: begin
        for (int b = 0; b < 4; b++) begin d[8*b +: 8] = 8'h07; c[b] = 1'b1; end
        d[39:32] = 8'hFB; c[4] = 1'b1;
      end
      4: begin
        d[8*p +: 8] = 8'hFD; c[p] = 1'b1;
        for (int b = p + 1; b < 8; b++) begin d[8*b +: 8] = 8'h07; c[b] = 1'b1; end
      end
      5: begin
        d[8*p +: 8] = 8'hFD; c[p] = 1'b1;
        for (int b = p + 1; b < 4; b++) begin d[8*b +: 8] = 8'h07; c[b] = 1'b1; end
        d[39:32] = 8'hFB; c[4] = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic send(input int kind, input int p, input logic [1:0] f, input bit r);
    logic [63:0] d;
    logic [7:0]  c;
    mk(kind, p, d, c);
    @(negedge clk);
    mtxd = d; mtxc = c; lf = f; rst = r;
    model_step(d, c, f, r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one output word per clock, compared against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("xgmii_txd", xtxd, e.d);
        chk("xgmii_txc", 64'(xtxc), 64'(e.c));
        chk("mac_tx_hold", 64'(hold), 64'(e.hold));
        chk("status_fault_tx", 64'(sft), 64'(e.stat));
`ifdef TX_FAULT_STATS_EN
        chk("stat_fault_entries", 64'(s_ent), 64'(e.ent));
        chk("stat_frames_dropped", 64'(s_drop), 64'(e.drop));
`endif
      end
    end
  end

  // Stimulus
  initial begin
    int   gen_len;
    bit   gen_in;
    int   dwell;
    int   v;
    int   p;
    logic [1:0] rf;
    rst = 1'b1; lf = 2'd0; mtxd = W_IDLE; mtxc = 8'hFF;

    send(0, 0, 2'd0, 1); send(0, 0, 2'd0, 1);
    repeat (5) send(0, 0, 2'd0, 0);                 // idle passthrough
    repeat (3) send(0, 0, 2'd1, 0);                 // local fault while idle
    repeat (HOLD + 4) send(0, 0, 2'd0, 0);          // hold then release

    // ten-word frame, local fault from word 3
    send(1, 0, 2'd0, 0); send(3, 0, 2'd0, 0); send(3, 0, 2'd0, 0);
    for (int w = 3; w < 9; w++) send(3, 0, 2'd1, 0);
    send(4, 5, 2'd1, 0);
    repeat (3) send(0, 0, 2'd1, 0);
    repeat (3) send(0, 0, 2'd2, 0);                 // switch to remote
    repeat (HOLD + 4) send(0, 0, 2'd0, 0);

    // frame started during override, hold expires mid-frame
    repeat (2) send(0, 0, 2'd1, 0);
    repeat (HOLD - 2) send(0, 0, 2'd0, 0);
    send(2, 0, 2'd0, 0);
    repeat (5) send(3, 0, 2'd0, 0);
    send(4, 3, 2'd0, 0);
    repeat (4) send(0, 0, 2'd0, 0);

    // illegal code 2'b11 behaves as local
    repeat (3) send(0, 0, 2'd3, 0);
    repeat (HOLD + 3) send(0, 0, 2'd0, 0);

    // reset for one clock mid-frame, during drain
    send(1, 0, 2'd0, 0); send(3, 0, 2'd1, 0);
    send(3, 0, 2'd1, 1);
    send(3, 0, 2'd0, 0); send(4, 2, 2'd0, 0);
    repeat (3) send(0, 0, 2'd0, 0);

    // randomized traffic with fault changes and occasional resets
    gen_in = 0; gen_len = 0; dwell = 0; rf = 2'd0;
    for (int n = 0; n < 4000; n++) begin
      bit r;
      r = ($urandom_range(0, 599) == 0);
      if (dwell == 0) begin
        v = $urandom_range(0, 9);
        rf = (v < 5) ? 2'd0 : (v < 7) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
        dwell = $urandom_range(1, 150);
      end else dwell--;
      if (!gen_in) begin
        if ($urandom_range(0, 3) == 0) begin
          send($urandom_range(1, 2), 0, rf, r);
          gen_in = 1; gen_len = $urandom_range(0, 12);
        end else send(0, 0, rf, r);
      end else if (gen_len > 0) begin
        send(3, 0, rf, r); gen_len--;
      end else begin
        p = $urandom_range(0, 7);
        if (p < 4 && $urandom_range(0, 3) == 0) begin
          send(5, p, rf, r); gen_len = $urandom_range(0, 12);
        end else begin
          send(4, p, rf, r); gen_in = 0;
        end
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
